// File: rtl/id_ex_hazard_ctrl.sv
// Hazard/stall sequencer for the ID/EX register: load-use stall, mult/div occupancy stall, taken-branch flush.
// Latency: zero-cycle combinational response to hazards; mdu stall spans MDU_LAT-1 cycles after accept.
// Backpressure: holds PC and IF/ID and bubbles ID/EX while stalled. Define HAZARD_PERF_CNT_EN to build the perf counters.
module id_ex_hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_mdu_op,
    input  logic             ex_memread,
    input  logic [4:0]       ex_writeaddr,
    input  logic             ex_branch_taken,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // Remaining BUSY cycles loaded on accept; a single-cycle mdu op never enters BUSY.
    localparam logic [3:0] LAT_M1 = 4'(MDU_LAT - 1);
    localparam bit         MULTI  = (MDU_LAT > 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       lu;
    logic       accept;

    // A load in EX writing a register the ID instruction reads; $0 never hazards.
    assign lu = ex_memread && (ex_writeaddr != 5'd0) &&
                ((id_uses_rs && (id_rs == ex_writeaddr)) ||
                 (id_uses_rt && (id_rt == ex_writeaddr)));

    // Mdu op only launches from IDLE when it is neither flushed nor held by a load-use stall.
    assign accept = (state == IDLE) && id_mdu_op && !ex_branch_taken && !lu;

    // State register: reset aborts any mdu sequence in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: IDLE->BUSY on accept, BUSY counts down to the last occupied cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept && MULTI) begin
                    state_nxt = BUSY;
                    cnt_nxt   = LAT_M1;
                end
            end
            BUSY: begin
                if (cnt == 4'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Output logic: reset, then branch flush in IDLE, then BUSY stall, then load-use stall.
    always_comb begin
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_stall = 1'b0;
        mdu_busy   = 1'b0;
        if (!rst) begin
            mdu_busy = (state == BUSY);
            if ((state == IDLE) && ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_stall = 1'b1;
            end else if (state == BUSY) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_stall = 1'b1;
            end else if (lu) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_stall = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    // Saturating perf counters for stalled-PC cycles and flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (pc_stall && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
            if (ifid_flush && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
module tb_id_ex_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_writeaddr;
    logic       id_uses_rs, id_uses_rt, id_mdu_op, ex_memread, ex_branch_taken;

    logic       pc4, ifs4, fl4, idx4, busy4;
    logic       pc1, ifs1, fl1, idx1, busy1;
    logic [3:0] st4, fc4, st1, fc1;

    int n_chk  = 0;
    int n_fail = 0;
    int e_st4 = 0, e_fc4 = 0, e_st1 = 0, e_fc1 = 0;

    always #5 clk = ~clk;

    id_ex_hazard_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_mdu_op(id_mdu_op),
        .ex_memread(ex_memread), .ex_writeaddr(ex_writeaddr), .ex_branch_taken(ex_branch_taken),
        .pc_stall(pc4), .ifid_stall(ifs4), .ifid_flush(fl4), .idex_stall(idx4), .mdu_busy(busy4),
        .stall_cycles(st4), .flush_count(fc4)
    );

    id_ex_hazard_ctrl #(.MDU_LAT(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_mdu_op(id_mdu_op),
        .ex_memread(ex_memread), .ex_writeaddr(ex_writeaddr), .ex_branch_taken(ex_branch_taken),
        .pc_stall(pc1), .ifid_stall(ifs1), .ifid_flush(fl1), .idex_stall(idx1), .mdu_busy(busy1),
        .stall_cycles(st1), .flush_count(fc1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Vectors are {pc_stall, ifid_stall, ifid_flush, idex_stall, mdu_busy}.
    task automatic chk_o(input string tag, input logic [4:0] e4, input logic [4:0] e1);
        chk({tag, "_lat4"}, {11'd0, pc4, ifs4, fl4, idx4, busy4}, {11'd0, e4});
        chk({tag, "_lat1"}, {11'd0, pc1, ifs1, fl1, idx1, busy1}, {11'd0, e1});
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_stall4"}, {12'd0, st4}, PERF ? 16'(e_st4) : 16'd0);
        chk({tag, "_flush4"}, {12'd0, fc4}, PERF ? 16'(e_fc4) : 16'd0);
        chk({tag, "_stall1"}, {12'd0, st1}, PERF ? 16'(e_st1) : 16'd0);
        chk({tag, "_flush1"}, {12'd0, fc1}, PERF ? 16'(e_fc1) : 16'd0);
    endtask

    function automatic int sat(input int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    // Advance one clock; expected counters follow the outputs expected this cycle.
    task automatic tick(input bit s4, input bit f4, input bit s1, input bit f1);
        if (rst) begin
            e_st4 = 0; e_fc4 = 0; e_st1 = 0; e_fc1 = 0;
        end else begin
            if (s4) e_st4 = sat(e_st4);
            if (f4) e_fc4 = sat(e_fc4);
            if (s1) e_st1 = sat(e_st1);
            if (f1) e_fc1 = sat(e_fc1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_rs = 5'd0; id_rt = 5'd0; ex_writeaddr = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_mdu_op = 1'b0;
        ex_memread = 1'b0; ex_branch_taken = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        clear_in();
        rst = 1'b1;
        #1;

        // Reset with every hazard input active: outputs stay quiet.
        ex_branch_taken = 1'b1; ex_memread = 1'b1; ex_writeaddr = 5'd5;
        id_uses_rs = 1'b1; id_rs = 5'd5; id_mdu_op = 1'b1;
        @(negedge clk); chk_o("reset", 5'b00000, 5'b00000);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);

        rst = 1'b0; clear_in();
        @(negedge clk); chk_o("post_reset", 5'b00000, 5'b00000); chk_cnt("post_reset");
        tick(0, 0, 0, 0);

        // Load-use through rs.
        ex_memread = 1'b1; ex_writeaddr = 5'd5; id_uses_rs = 1'b1; id_rs = 5'd5;
        @(negedge clk); chk_o("lu_rs", 5'b11010, 5'b11010);
        tick(1, 0, 1, 0);

        ex_memread = 1'b0;
        @(negedge clk); chk_o("lu_clear", 5'b00000, 5'b00000);
        tick(0, 0, 0, 0);

        // Destination $0 never stalls.
        ex_memread = 1'b1; ex_writeaddr = 5'd0; id_rs = 5'd0;
        @(negedge clk); chk_o("lu_zero", 5'b00000, 5'b00000);
        tick(0, 0, 0, 0);

        // rs matches but is unused; rt used and differs.
        ex_writeaddr = 5'd5; id_uses_rs = 1'b0; id_rs = 5'd5; id_uses_rt = 1'b1; id_rt = 5'd3;
        @(negedge clk); chk_o("lu_unused_rs", 5'b00000, 5'b00000);
        tick(0, 0, 0, 0);

        // Load-use through rt.
        id_rt = 5'd5;
        @(negedge clk); chk_o("lu_rt", 5'b11010, 5'b11010);
        tick(1, 0, 1, 0);

        // Mdu accept, then three BUSY cycles (MDU_LAT=4); MDU_LAT=1 never busy.
        clear_in(); id_mdu_op = 1'b1;
        @(negedge clk); chk_o("mdu_accept", 5'b00000, 5'b00000);
        tick(0, 0, 0, 0);
        id_mdu_op = 1'b0;
        @(negedge clk); chk_o("mdu_busy1", 5'b11011, 5'b00000);
        tick(1, 0, 0, 0);
        ex_branch_taken = 1'b1;
        @(negedge clk); chk_o("mdu_busy2_br", 5'b11011, 5'b00110);
        tick(1, 0, 0, 1);
        ex_branch_taken = 1'b0;
        @(negedge clk); chk_o("mdu_busy3", 5'b11011, 5'b00000);
        tick(1, 0, 0, 0);
        @(negedge clk); chk_o("mdu_done", 5'b00000, 5'b00000); chk_cnt("mdu_done");
        tick(0, 0, 0, 0);

        // Load-use with mdu op: stall first, accept the following cycle.
        ex_memread = 1'b1; ex_writeaddr = 5'd7; id_uses_rt = 1'b1; id_rt = 5'd7; id_mdu_op = 1'b1;
        @(negedge clk); chk_o("lu_mdu", 5'b11010, 5'b11010);
        tick(1, 0, 1, 0);
        ex_memread = 1'b0;
        @(negedge clk); chk_o("lu_mdu_accept", 5'b00000, 5'b00000);
        tick(0, 0, 0, 0);
        id_mdu_op = 1'b0;
        @(negedge clk); chk_o("lu_mdu_busy1", 5'b11011, 5'b00000);
        tick(1, 0, 0, 0);

        // Reset in the second BUSY cycle.
        rst = 1'b1;
        @(negedge clk); chk_o("rst_in_busy", 5'b00000, 5'b00000);
        tick(0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk); chk_o("rst_release", 5'b00000, 5'b00000); chk_cnt("rst_release");
        tick(0, 0, 0, 0);

        // Branch with load-use and mdu op: flush wins, nothing accepted.
        ex_branch_taken = 1'b1; ex_memread = 1'b1; ex_writeaddr = 5'd5;
        id_uses_rs = 1'b1; id_rs = 5'd5; id_mdu_op = 1'b1;
        @(negedge clk); chk_o("br_lu_mdu", 5'b00110, 5'b00110);
        tick(0, 1, 0, 1);
        clear_in();
        @(negedge clk); chk_o("br_stays_idle", 5'b00000, 5'b00000);
        tick(0, 0, 0, 0);

        // Twenty load-use stall cycles saturate a 4-bit counter.
        ex_memread = 1'b1; ex_writeaddr = 5'd9; id_uses_rs = 1'b1; id_rs = 5'd9;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 10) chk_o("lu_long", 5'b11010, 5'b11010);
            tick(1, 0, 1, 0);
        end
        clear_in();
        @(negedge clk); chk_o("sat_idle", 5'b00000, 5'b00000); chk_cnt("saturate");
        chk("stall_sat_value", {12'd0, st4}, PERF ? 16'd15 : 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_ctrl.md
# id_ex_hazard_ctrl

Hazard and stall controller that sequences the ID/EX pipeline register of the five-stage MIPS core. It detects load-use hazards, stalls the front end while a multi-cycle multiply/divide occupies EX, and flushes wrong-path instructions on a taken branch resolved in EX. It drives the PC stall, the IF/ID stall and flush, and the ID/EX `stall` input, which zeroes every ID/EX output and so inserts a bubble.

## Interface
Parameters:
- `MDU_LAT`, 4: total EX-occupancy cycles of a mult/div instruction; legal range 1..16.
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_rs` in 5: rs field of the instruction in ID.
- `id_rt` in 5: rt field of the instruction in ID.
- `id_uses_rs` in 1: ID instruction reads rs.
- `id_uses_rt` in 1: ID instruction reads rt.
- `id_mdu_op` in 1: ID instruction is a mult/div.
- `ex_memread` in 1: the EX instruction is a load (the ID/EX `EX_memread`).
- `ex_writeaddr` in 5: destination of the EX instruction (the ID/EX `EX_writeaddr`).
- `ex_branch_taken` in 1: a branch or jump resolved taken in EX this cycle.
- `pc_stall` out 1: hold the PC.
- `ifid_stall` out 1: hold the IF/ID register.
- `ifid_flush` out 1: clear IF/ID to a NOP.
- `idex_stall` out 1: to the ID/EX `stall` input; loads a bubble.
- `mdu_busy` out 1: FSM is in BUSY.
- `stall_cycles` out CNT_W: stall performance counter.
- `flush_count` out CNT_W: flush performance counter.

## Operation
- Load-use hazard `lu`: `ex_memread && ex_writeaddr != 0 && ((id_uses_rs && id_rs == ex_writeaddr) || (id_uses_rt && id_rt == ex_writeaddr))`.
- FSM states:
  - IDLE, reset state.
  - BUSY, with a 4-bit down-counter `cnt`.
- Output priority, highest first; all outputs are combinational from the state and the inputs:
  1. `rst`=1: all outputs 0.
  2. `ex_branch_taken` in IDLE: `ifid_flush`=1 and `idex_stall`=1. `pc_stall` and `ifid_stall` are 0, so the target is fetched.
  3. BUSY: `pc_stall`, `ifid_stall` and `idex_stall` all 1. `ex_branch_taken` is ignored, because EX holds only the mdu op or bubbles.
  4. `lu` in IDLE: `pc_stall`, `ifid_stall` and `idex_stall` all 1 for exactly one cycle. The load advances to MEM, so `lu` clears next cycle and forwarding handles the rest.
  5. Otherwise all outputs are 0.
- Accept rule: an mdu op is accepted when `id_mdu_op`=1 in IDLE with no branch flush and no `lu` that cycle.
- IDLE→BUSY transition:
  - On accept with `MDU_LAT`>1, go to BUSY next cycle with `cnt`=`MDU_LAT`-1. The mdu op is then in EX.
  - With `MDU_LAT`=1, the FSM stays in IDLE.
- BUSY behaviour:
  - `cnt` decrements each cycle.
  - When `cnt`==1, the next state is IDLE.
  - BUSY therefore lasts exactly `MDU_LAT`-1 cycles.
  - The instruction after the mdu op enters EX `MDU_LAT` cycles after the mdu op enters EX.
- `mdu_busy` equals (state==BUSY) and is 0 while `rst` is asserted.

## Timing
- Load-use and branch responses have zero latency: outputs assert in the same cycle the condition is present on the inputs.
- The mdu stall begins the cycle after accept and ends after `MDU_LAT`-1 cycles.
- Reset:
  - State returns to IDLE, `cnt`=0, counters=0.
  - All outputs are 0 during and after reset until a hazard input is present.
  - A reset during BUSY aborts the sequence; state is IDLE at the next edge.
- Simultaneous events:
  - Branch together with `lu`: flush wins. `lu` is ignored and no stall occurs.
  - Branch together with `id_mdu_op` in IDLE: the mdu op is flushed and not accepted.
  - `lu` together with `id_mdu_op`: the load-use stall occurs first, and the mdu op is accepted the following cycle.
  - `ex_writeaddr`=0 never causes a load-use stall.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cycles` increments every cycle with `pc_stall`=1.
  - `flush_count` increments every cycle with `ifid_flush`=1.
  - Both saturate at all-ones and clear on `rst`.
- `HAZARD_PERF_CNT_EN` undefined: both ports remain but are tied to 0, and no counter flops are built.

## Test plan
- `lw` to $5 in EX (`ex_memread`=1, `ex_writeaddr`=5) with ID using rs=5 → `pc_stall`/`ifid_stall`/`idex_stall`=1 for one cycle. The next cycle, with `ex_memread`=0, all outputs are 0.
- Same as above but `ex_writeaddr`=0, or `id_uses_rs`=0 with `id_rt`≠5 → no stall.
- `MDU_LAT`=4, `id_mdu_op`=1 in IDLE → `mdu_busy` and all stalls are 1 for exactly 3 cycles starting the next cycle, then IDLE. Repeat with `MDU_LAT`=1 → never BUSY.
- `ex_branch_taken`=1 together with `lu` and `id_mdu_op` → `ifid_flush`=1, `idex_stall`=1, `pc_stall`=0, FSM stays IDLE.
- Assert `rst` in the second BUSY cycle → all outputs 0. After release: IDLE, counters 0.
- With `HAZARD_PERF_CNT_EN`, `CNT_W`=4: 20 stall cycles → `stall_cycles`=15 (saturated). Without the macro → `stall_cycles`=0.
